// File: rtl/riscv_fetch_btb.sv
// ============================================================================
// riscv_fetch_btb : RISC-V fetch stage with a direct-mapped branch target buffer
// Revision 1.0
// ============================================================================
`default_nettype none

module riscv_fetch_btb #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pcplus4_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = XLEN - IW - 2;

    logic [XLEN-1:0]        pc_q, pc_d;
    logic                   instr_valid_q;
    logic [31:0]            instr_q;
    logic [XLEN-1:0]        pc_out_q;
    logic [XLEN-1:0]        pcplus4_q;
    logic                   pred_taken_q;
    logic [XLEN-1:0]        pred_target_q;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [1:0]             cnt_q [BTB_ENTRIES];
    logic [TW-1:0]          tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];

    logic [IW-1:0]          lk_idx;
    logic [TW-1:0]          lk_tag;
    logic                   lk_hit;
    logic                   lk_taken;
    logic [XLEN-1:0]        lk_target;
    logic [XLEN-1:0]        pc_plus4;
    logic [XLEN-1:0]        next_pc;

    logic [IW-1:0]          up_idx;
    logic [TW-1:0]          up_tag;
    logic                   up_hit;
    logic [1:0]             up_cnt;
    logic [1:0]             up_cnt_inc;
    logic [1:0]             up_cnt_dec;
    logic                   unused_upd_lsb;

    // Lookup reads only registered state, so a same-cycle update is invisible here.
    assign lk_idx    = pc_q[IW+1:2];
    assign lk_tag    = pc_q[XLEN-1:IW+2];
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && cnt_q[lk_idx][1];
    assign lk_target = lk_taken ? tgt_q[lk_idx] : '0;
    assign pc_plus4  = pc_q + XLEN'(4);
    assign next_pc   = lk_taken ? tgt_q[lk_idx] : pc_plus4;

    assign up_idx     = upd_pc_i[IW+1:2];
    assign up_tag     = upd_pc_i[XLEN-1:IW+2];
    assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_cnt     = cnt_q[up_idx];
    assign up_cnt_inc = (up_cnt == 2'b11) ? 2'b11 : up_cnt + 2'd1;
    assign up_cnt_dec = (up_cnt == 2'b00) ? 2'b00 : up_cnt - 2'd1;
    assign unused_upd_lsb = ^upd_pc_i[1:0];

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (!stall_i && imem_ready_i) begin
            pc_d = next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            pc_out_q      <= '0;
            pcplus4_q     <= '0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid_i) begin
                instr_valid_q <= 1'b0;
            end else if (!stall_i) begin
                if (imem_ready_i) begin
                    instr_valid_q <= 1'b1;
                    instr_q       <= imem_rdata_i;
                    pc_out_q      <= pc_q;
                    pcplus4_q     <= pc_plus4;
                    pred_taken_q  <= lk_taken;
                    pred_target_q <= lk_target;
                end else begin
                    instr_valid_q <= 1'b0;
                end
            end
        end
    end

    // Valid bits and counters are reset; tags and targets are masked by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else if (upd_valid_i) begin
            if (upd_taken_i) begin
                valid_q[up_idx] <= 1'b1;
                cnt_q[up_idx]   <= up_hit ? up_cnt_inc : 2'b10;
            end else if (up_hit) begin
                cnt_q[up_idx]   <= up_cnt_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_valid_i && upd_taken_i) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= upd_target_i;
        end
    end

    assign imem_req_o    = rst_n;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;
    assign pcplus4_o     = pcplus4_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_target_o = pred_target_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_fetch_btb.sv
// ============================================================================
// tb_riscv_fetch_btb : self-checking bench for riscv_fetch_btb (XLEN=32, 16 entries)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_riscv_fetch_btb;

    localparam int          N = 16;
    localparam logic [31:0] K = 32'h1357_2468;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_tgt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ready;
    logic [31:0] rdata;
    logic        iv;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc4;
    logic        ptaken;
    logic [31:0] ptgt;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 0;

    riscv_fetch_btb #(.XLEN(32), .BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall),
        .redirect_valid_i(redir),
        .redirect_pc_i   (redir_pc),
        .upd_valid_i     (upd_valid),
        .upd_pc_i        (upd_pc),
        .upd_taken_i     (upd_taken),
        .upd_target_i    (upd_tgt),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ready_i    (ready),
        .imem_rdata_i    (rdata),
        .instr_valid_o   (iv),
        .instr_o         (instr),
        .pc_o            (pc_out),
        .pcplus4_o       (pc4),
        .pred_taken_o    (ptaken),
        .pred_target_o   (ptgt)
    );

    // Instruction memory returns an address-derived word so data can be predicted.
    assign rdata = imem_addr ^ K;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: BTB as plain arrays, counter as an integer 0..3
    logic [31:0] m_pc, m_instr, m_pco, m_pc4, m_ptgt;
    bit          m_iv, m_pt;
    bit          m_valid [N];
    int          m_cnt   [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          li, ui;
    bit          lhit, lpt, uhit;
    logic [31:0] ltgt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_iv = 0; m_instr = 0; m_pco = 0; m_pc4 = 0; m_pt = 0; m_ptgt = 0;
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_cnt[i]   = 1;
            end
        end else begin
            li   = int'((m_pc >> 2) % N);
            lhit = m_valid[li] && (m_tag[li] == (m_pc >> 6));
            lpt  = lhit && (m_cnt[li] >= 2);
            ltgt = m_tgt[li];
            if (redir) begin
                m_pc = redir_pc;
                m_iv = 0;
            end else if (!stall) begin
                if (ready) begin
                    m_instr = m_pc ^ K;
                    m_pco   = m_pc;
                    m_pc4   = m_pc + 4;
                    m_pt    = lpt;
                    m_ptgt  = ltgt;
                    m_iv    = 1;
                    m_pc    = lpt ? ltgt : m_pc + 4;
                end else begin
                    m_iv = 0;
                end
            end
            if (upd_valid) begin
                ui   = int'((upd_pc >> 2) % N);
                uhit = m_valid[ui] && (m_tag[ui] == (upd_pc >> 6));
                if (upd_taken) begin
                    m_cnt[ui]   = uhit ? ((m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1) : 2;
                    m_valid[ui] = 1;
                    m_tag[ui]   = upd_pc >> 6;
                    m_tgt[ui]   = upd_tgt;
                end else if (uhit) begin
                    m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("imem_req",    imem_req,  rst_n);
            chk("imem_addr",   imem_addr, m_pc);
            chk("instr_valid", iv,        m_iv);
            chk("instr",       instr,     m_instr);
            chk("pc_o",        pc_out,    m_pco);
            chk("pcplus4",     pc4,       m_pc4);
            chk("pred_taken",  ptaken,    m_pt);
            if (m_pt) chk("pred_target", ptgt, m_ptgt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redir = 1; redir_pc = pc;
        tick();
        redir = 0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid = 1; upd_pc = pc; upd_taken = taken; upd_tgt = tgt;
    endtask

    logic [31:0] pc_tab [5];

    initial begin
        pc_tab[0] = 32'h10; pc_tab[1] = 32'h50; pc_tab[2] = 32'h90;
        pc_tab[3] = 32'h100; pc_tab[4] = 32'h14;
        rst_n = 0; stall = 0; redir = 0; redir_pc = 0; upd_valid = 0; upd_pc = 0;
        upd_taken = 0; upd_tgt = 0; ready = 1;
        tick();
        checking = 1;
        tick();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_iv", iv, 1'b0);
        chk("rst_pc_o", pc_out, 32'h0);
        chk("rst_ptaken", ptaken, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        rst_n = 1;

        // Sequential fetch
        tick();
        chk("seq_addr1", imem_addr, 32'h4);
        chk("seq_iv1", iv, 1'b1);
        chk("seq_pc1", pc_out, 32'h0);
        chk("seq_instr1", instr, 32'h1357_2468);
        tick();
        chk("seq_addr2", imem_addr, 32'h8);
        chk("seq_pc2", pc_out, 32'h4);

        // Train 0x10 -> 0x40
        update(32'h10, 1, 32'h40);
        tick();
        upd_valid = 0;
        tick();
        chk("train_addr", imem_addr, 32'h10);
        tick();
        chk("train_ptaken", ptaken, 1'b1);
        chk("train_ptgt", ptgt, 32'h40);
        chk("train_next", imem_addr, 32'h40);
        chk("train_pc", pc_out, 32'h10);

        // Two not-taken updates drive the counter to 00
        update(32'h10, 0, 32'h0);
        tick();
        tick();
        upd_valid = 0;
        redirect_to(32'h10);
        chk("redir_addr", imem_addr, 32'h10);
        chk("redir_iv", iv, 1'b0);
        tick();
        chk("untrain_ptaken", ptaken, 1'b0);
        chk("untrain_next", imem_addr, 32'h14);

        // Redirect wins over a simultaneous stall
        stall = 1;
        redirect_to(32'h200);
        chk("rs_addr", imem_addr, 32'h200);
        chk("rs_iv", iv, 1'b0);
        stall = 0;
        tick();
        chk("rs_fetch_addr", imem_addr, 32'h204);
        chk("rs_fetch_pc", pc_out, 32'h200);

        // Three-cycle stall holds everything
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", imem_addr, 32'h204);
            chk("stall_pc", pc_out, 32'h200);
            chk("stall_instr", instr, 32'h200 ^ 32'h1357_2468);
            chk("stall_iv", iv, 1'b1);
        end
        stall = 0;
        ready = 0;
        tick();
        chk("bubble_iv", iv, 1'b0);
        chk("bubble_addr", imem_addr, 32'h204);
        chk("bubble_pc", pc_out, 32'h200);
        ready = 1;

        // Alias eviction: 0x10 and 0x50 share index 4
        update(32'h10, 1, 32'h80);
        tick();
        update(32'h50, 1, 32'h90);
        tick();
        upd_valid = 0;
        redirect_to(32'h10);
        tick();
        chk("alias_ptaken", ptaken, 1'b0);
        chk("alias_next", imem_addr, 32'h14);

        // Same-cycle update and lookup: lookup sees counter 10, write makes it 01
        redirect_to(32'h50);
        update(32'h50, 0, 32'h0);
        tick();
        upd_valid = 0;
        chk("same_ptaken", ptaken, 1'b1);
        chk("same_ptgt", ptgt, 32'h90);
        chk("same_next", imem_addr, 32'h90);
        redirect_to(32'h50);
        tick();
        chk("same_after", imem_addr, 32'h54);

        // Wrap-around
        redirect_to(32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0);
        chk("wrap_next", imem_addr, 32'h0);

        // Mixed traffic, model-checked every cycle
        for (int i = 0; i < 60; i++) begin
            stall     = ($urandom_range(0, 3) == 0);
            ready     = ($urandom_range(0, 3) != 0);
            redir     = ($urandom_range(0, 7) == 0);
            redir_pc  = pc_tab[$urandom_range(0, 4)];
            upd_valid = ($urandom_range(0, 2) == 0);
            upd_pc    = pc_tab[$urandom_range(0, 4)];
            upd_taken = 1'($urandom_range(0, 1));
            upd_tgt   = pc_tab[$urandom_range(0, 4)];
            tick();
        end
        stall = 0; ready = 1; redir = 0; upd_valid = 0;

        // Retrain 0x10 then reset mid-stall/mid-redirect
        update(32'h10, 1, 32'h40);
        tick();
        tick();
        upd_valid = 0;
        redirect_to(32'h10);
        tick();
        chk("retrain_next", imem_addr, 32'h40);
        stall = 1; redir = 1; redir_pc = 32'h300;
        rst_n = 0;
        #1;
        chk("arst_iv", iv, 1'b0);
        chk("arst_pc_o", pc_out, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_pc4", pc4, 32'h0);
        chk("arst_ptaken", ptaken, 1'b0);
        chk("arst_addr", imem_addr, 32'h0);
        tick();
        rst_n = 1; stall = 0; redir = 0;
        tick();
        chk("post_rst_pc", pc_out, 32'h0);
        chk("post_rst_addr", imem_addr, 32'h4);
        redirect_to(32'h10);
        tick();
        chk("post_rst_ptaken", ptaken, 1'b0);
        chk("post_rst_next", imem_addr, 32'h14);
        tick();
        tick();
        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
